// File: rtl/riscv_apu_resp_pkg.sv
// riscv_apu_resp_pkg: op encoding, latency classes and pipe entry type for the APU responder
package riscv_apu_resp_pkg;
  localparam int unsigned APU_RESP_WIDTH = 32;
  typedef enum logic [1:0] {
    APU_OP_ADD = 2'd0,
    APU_OP_SUB = 2'd1,
    APU_OP_MUL = 2'd2,
    APU_OP_MAC = 2'd3
  } apu_resp_op_e;
  localparam logic [1:0] APU_LAT_0 = 2'd0;
  localparam logic [1:0] APU_LAT_1 = 2'd1;
  localparam logic [1:0] APU_LAT_2 = 2'd2;
  localparam logic [1:0] APU_LAT_3 = 2'd3;
  typedef struct packed {
    logic [APU_RESP_WIDTH-1:0] result;
    logic [1:0]                flags;
  } apu_resp_entry_t;
endpackage

// File: rtl/riscv_apu_responder_if.sv
// riscv_apu_responder_if: req/gnt request channel and valid/ready response channel of the APU link
interface riscv_apu_responder_if
  import riscv_apu_resp_pkg::*;
#(
  parameter int unsigned WIDTH = APU_RESP_WIDTH
);
  logic                  req;
  logic                  gnt;
  apu_resp_op_e          op;
  logic [1:0]            lat;
  logic [2:0][WIDTH-1:0] operands;
  logic                  valid;
  logic                  ready;
  logic [WIDTH-1:0]      result;
  logic [1:0]            flags;
  modport master (output req, op, lat, operands, ready, input gnt, valid, result, flags);
  modport slave (input req, op, lat, operands, ready, output gnt, valid, result, flags);
endinterface

// File: rtl/riscv_apu_resp_alu.sv
// riscv_apu_resp_alu: combinational op/operands -> result/flags; MAC adder present only with APU_RESPONDER_MAC_EN
module riscv_apu_resp_alu
  import riscv_apu_resp_pkg::*;
#(
  parameter int unsigned WIDTH = APU_RESP_WIDTH
) (
  input  apu_resp_op_e          op_i,
  input  logic [2:0][WIDTH-1:0] operands_i,
  output apu_resp_entry_t       entry_o
);
  logic [WIDTH-1:0] a, b, prod, res;
  logic ill;
  assign a = operands_i[0];
  assign b = operands_i[1];
  assign prod = a * b;
`ifdef APU_RESPONDER_MAC_EN
  assign ill = 1'b0;
  assign res = op_i == APU_OP_ADD ? a + b
             : op_i == APU_OP_SUB ? a - b
             : op_i == APU_OP_MUL ? prod
             : prod + operands_i[2];
`else
  logic unused_c;
  assign unused_c = ^operands_i[2];
  assign ill = op_i == APU_OP_MAC;
  assign res = op_i == APU_OP_ADD ? a + b
             : op_i == APU_OP_SUB ? a - b
             : op_i == APU_OP_MUL ? prod
             : '0;
`endif
  assign entry_o.result = res;
  assign entry_o.flags = {ill, ~ill & (res == '0)};
endmodule

// File: rtl/riscv_apu_responder.sv
// riscv_apu_responder: in-order fixed-latency APU slave (scheduler, 2-deep pipe, multicycle hold); op 3 is MAC only with APU_RESPONDER_MAC_EN
module riscv_apu_responder
  import riscv_apu_resp_pkg::*;
#(
  parameter int unsigned WIDTH       = APU_RESP_WIDTH,
  parameter int unsigned ITER_CYCLES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  riscv_apu_responder_if.slave        apu_slave,
  output logic                        busy_o
);
  localparam int unsigned CW = $clog2(ITER_CYCLES);
  apu_resp_entry_t       alu_e, hold_q, out_e;
  apu_resp_entry_t [1:0] pipe_q;
  logic [1:0]            occ_q;
  logic [CW-1:0]         mc_q;
  logic [1:0]            lat;
  logic                  held, mc_busy, mc_rel, lat_ok, gnt, g0, g1, g2, g3;
  riscv_apu_resp_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i      (apu_slave.op),
    .operands_i(apu_slave.operands),
    .entry_o   (alu_e)
  );
  assign lat = apu_slave.lat;
  assign held = occ_q[0] & ~apu_slave.ready;
  assign mc_busy = mc_q != '0;
  assign mc_rel = mc_q == CW'(1);
  assign lat_ok = lat == APU_LAT_0 ? ~|occ_q & apu_slave.ready
                : lat == APU_LAT_1 ? ~occ_q[1]
                : lat == APU_LAT_2 ? 1'b1
                : ~|occ_q;
  assign gnt = ~rst_i & apu_slave.req & ~held & ~mc_busy & lat_ok;
  assign g0 = gnt & (lat == APU_LAT_0);
  assign g1 = gnt & (lat == APU_LAT_1);
  assign g2 = gnt & (lat == APU_LAT_2);
  assign g3 = gnt & (lat == APU_LAT_3);
  assign out_e = occ_q[0] ? pipe_q[0] : g0 ? alu_e : '0;
  assign apu_slave.gnt = gnt;
  assign apu_slave.valid = occ_q[0] | g0;
  assign apu_slave.result = out_e.result;
  assign apu_slave.flags = out_e.flags;
  assign busy_o = |occ_q | mc_busy | held;
  // advance the return schedule one slot per cycle unless the head result is held by the master
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= '0;
      mc_q   <= '0;
      pipe_q <= '0;
      hold_q <= '0;
    end else if (!held) begin
      occ_q[1]  <= g2;
      occ_q[0]  <= occ_q[1] | g1 | mc_rel;
      pipe_q[0] <= mc_rel ? hold_q : occ_q[1] ? pipe_q[1] : alu_e;
      if (g2) pipe_q[1] <= alu_e;
      if (g3) hold_q <= alu_e;
      mc_q <= g3 ? CW'(ITER_CYCLES - 1) : mc_busy ? mc_q - 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_riscv_apu_responder.sv
// tb_riscv_apu_responder: directed and random stimulus against a due-time queue model of the responder
module tb_riscv_apu_responder;
  import riscv_apu_resp_pkg::*;
  localparam int ITER = 4;
  typedef struct {
    int          d;
    bit          mc;
    logic [31:0] r;
    logic [1:0]  f;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  logic busy;
  int n_vec = 0;
  int n_err = 0;
  ent_t q[$];
  logic obs_g, obs_v;
  logic [31:0] obs_r;
  logic [1:0] obs_f;
  riscv_apu_responder_if #(.WIDTH(32)) bus ();
  riscv_apu_responder #(.WIDTH(32), .ITER_CYCLES(ITER)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .apu_slave(bus),
    .busy_o   (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] ref_alu(input logic [1:0] op, input logic [31:0] a, b, c);
    logic [31:0] r, m;
    m = 32'(64'(a) * 64'(b) + 64'(c));
    r = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? 32'(64'(a) * 64'(b)) : m;
`ifndef APU_RESPONDER_MAC_EN
    if (op == 2'd3) return {2'b10, 32'h0};
`endif
    return {1'b0, r == 32'h0, r};
  endfunction
  task automatic step(input bit rq, input logic [1:0] op, input logic [1:0] lat,
                      input logic [31:0] a, b, c, input bit rdy, input bit rs);
    logic [33:0] e;
    bit hv, held, mc, lim, ok, ev;
    logic [31:0] er;
    logic [1:0] ef;
    @(posedge clk);
    #1;
    rst = rs;
    bus.req = rq;
    bus.op = apu_resp_op_e'(op);
    bus.lat = lat;
    bus.operands = {c, b, a};
    bus.ready = rdy;
    @(negedge clk);
    e = ref_alu(op, a, b, c);
    hv = q.size() > 0 && q[0].d == 0;
    held = hv && !rdy;
    mc = 0;
    lim = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].mc && q[i].d > 0) mc = 1;
      if (q[i].d >= int'(lat)) lim = 1;
    end
    ok = rq && !rs && !held && !mc &&
         (lat == 2'd3 ? q.size() == 0 : lat == 2'd0 ? q.size() == 0 && rdy : !lim);
    ev = hv || (ok && lat == 2'd0);
    er = hv ? q[0].r : (ok && lat == 2'd0) ? e[31:0] : 32'h0;
    ef = hv ? q[0].f : (ok && lat == 2'd0) ? e[33:32] : 2'b00;
    obs_g = bus.gnt;
    obs_v = bus.valid;
    obs_r = bus.result;
    obs_f = bus.flags;
    chk("gnt", 64'(bus.gnt), 64'(ok));
    if (!rs) begin
      chk("valid", 64'(bus.valid), 64'(ev));
      chk("result", 64'(bus.result), 64'(er));
      chk("flags", 64'(bus.flags), 64'(ef));
      chk("busy", 64'(busy), 64'(q.size() != 0));
    end
    if (rs) q.delete();
    else if (!held) begin
      if (hv) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) q[i].d = q[i].d - 1;
      if (ok && lat != 2'd0)
        q.push_back('{lat == 2'd3 ? ITER - 1 : int'(lat) - 1, lat == 2'd3, e[31:0], e[33:32]});
    end
  endtask
  initial begin
    int waited, cnt;
    logic [31:0] a, b, c, mres;
    bus.req = 0;
    bus.op = APU_OP_ADD;
    bus.lat = 0;
    bus.operands = '0;
    bus.ready = 1;
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 5, 7, 0, 1, 0);
    chk("add0_gnt", 64'(obs_g), 1);
    chk("add0_valid", 64'(obs_v), 1);
    chk("add0_res", 64'(obs_r), 12);
    chk("add0_flags", 64'(obs_f), 0);
    step(1, 1, 2, 3, 3, 0, 1, 0);
    chk("sub2_gnt", 64'(obs_g), 1);
    waited = -1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 1, 1, 0, 1, 0);
      if (obs_g) begin
        waited = i;
        break;
      end
    end
    chk("inorder_wait", 64'(waited), 1);
    chk("sub2_flags", 64'(obs_f), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("add1_res", 64'(obs_r), 2);
    step(1, 2, 3, 32'hFFFF_FFFF, 2, 0, 1, 0);
    chk("mul3_gnt", 64'(obs_g), 1);
    waited = -1;
    mres = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 5, 7, 0, 1, 0);
      if (obs_v && !obs_g) mres = obs_r;
      if (obs_g) begin
        waited = i;
        break;
      end
    end
    chk("mc_refusals", 64'(waited), 4);
    chk("mul3_res", 64'(mres), 64'hFFFF_FFFE);
    step(1, 0, 1, 10, 20, 0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 30, 40, 0, 0, 0);
      cnt += int'(obs_g);
      chk("stall_res", 64'(obs_r), 30);
    end
    chk("stall_gnts", 64'(cnt), 0);
    step(1, 0, 1, 30, 40, 0, 1, 0);
    chk("unstall_gnt", 64'(obs_g), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("post_stall", 64'(obs_r), 70);
    step(1, 3, 1, 2, 3, 4, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef APU_RESPONDER_MAC_EN
    chk("mac_res", 64'(obs_r), 10);
    chk("mac_flags", 64'(obs_f), 0);
`else
    chk("mac_res", 64'(obs_r), 0);
    chk("mac_flags", 64'(obs_f), 2);
`endif
    step(1, 1, 2, 9, 4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    cnt = 0;
    repeat (4) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      cnt += int'(obs_v);
    end
    chk("rst_drop", 64'(cnt), 0);
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      c = $urandom;
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           a, b, c, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
